// File: rtl/switch_debounce.sv
// switch_debounce: debounces eight raw board switches.
// Each bit is double-flop synchronized, then must disagree with its debounced
// value for DEBOUNCE_CYCLES consecutive edges before the debounced value
// follows it. VALID marks the end of the post-reset settling window, and
// CHANGED strobes for one cycle whenever the debounced value moves after that.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SWITCH,
  output logic [7:0] O,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       VALID,
  output logic       CHANGED
);

  // Terminal count of a per-bit counter: reaching it with the mismatch still
  // present means the input has been stable for DEBOUNCE_CYCLES edges.
  localparam logic [15:0] CNT_MAX     = 16'(DEBOUNCE_CYCLES - 1);
  // Edge index (first edge after release is edge 0) at which VALID rises;
  // one edge after the initial value can have reached O.
  localparam logic [16:0] SETTLE_EDGE = 17'(DEBOUNCE_CYCLES + 2);

  logic [7:0]  sync1_reg;
  logic [7:0]  sync2_reg;
  logic [7:0]  o_reg;
  logic [7:0]  o_next;
  logic [15:0] cnt_reg  [8];
  logic [15:0] cnt_next [8];
  logic [16:0] settle_reg;
  logic        valid_reg;
  logic        changed_reg;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_reg <= 8'h00;
      sync2_reg <= 8'h00;
    end else begin
      sync1_reg <= SWITCH;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debounce: an independent counter per switch, cleared whenever the
  // synchronized input agrees with the debounced value again.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      logic mismatch;
      logic done;

      assign mismatch     = (sync2_reg[gi] != o_reg[gi]);
      assign done         = mismatch && (cnt_reg[gi] == CNT_MAX);
      assign o_next[gi]   = done ? sync2_reg[gi] : o_reg[gi];
      assign cnt_next[gi] = (mismatch && !done) ? (cnt_reg[gi] + 16'd1) : 16'd0;

      // Stability counter for this bit.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          cnt_reg[gi] <= 16'd0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  // Debounced value and change strobe; the strobe is suppressed while the
  // settling window is still open so the initial load is not reported.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      o_reg       <= 8'h00;
      changed_reg <= 1'b0;
    end else begin
      o_reg       <= o_next;
      changed_reg <= valid_reg && (o_next != o_reg);
    end
  end

  // Settling window: count edges since reset release, then hold VALID high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      settle_reg <= 17'd0;
      valid_reg  <= 1'b0;
    end else if (!valid_reg) begin
      settle_reg <= settle_reg + 17'd1;
      if (settle_reg == SETTLE_EDGE) begin
        valid_reg <= 1'b1;
      end
    end
  end

  assign O       = o_reg;
  assign A       = o_reg[3:0];
  assign B       = o_reg[7:4];
  assign VALID   = valid_reg;
  assign CHANGED = changed_reg;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed testbench for switch_debounce with DEBOUNCE_CYCLES = 4.
// Edge k = 0 is the first rising edge at which a new input value is sampled
// (or the first edge after reset release); with 4 cycles a clean step reaches
// O at k = 5 and CHANGED is seen in the cycle after that same edge (k = 5).
module tb_switch_debounce;

  logic       CLK;
  logic       RESET;
  logic [7:0] SWITCH;
  logic [7:0] O;
  logic [3:0] A;
  logic [3:0] B;
  logic       VALID;
  logic       CHANGED;

  int checks = 0;
  int errors = 0;

  switch_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SWITCH  (SWITCH),
    .O       (O),
    .A       (A),
    .B       (B),
    .VALID   (VALID),
    .CHANGED (CHANGED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Release reset between edges and check the power-up settling sequence.
  task automatic run_settle(input string tag);
    logic [7:0] exp_o;
    logic       exp_v;
    #3;
    RESET = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_o = (k >= 5) ? 8'hA5 : 8'h00;
      exp_v = (k >= 6);
      checks++;
      if (O !== exp_o) begin
        errors++;
        $display("FAIL %s_o k=%0d got %h expected %h", tag, k, O, exp_o);
      end
      checks++;
      if (VALID !== exp_v) begin
        errors++;
        $display("FAIL %s_valid k=%0d got %b expected %b", tag, k, VALID, exp_v);
      end
      checks++;
      if (CHANGED !== 1'b0) begin
        errors++;
        $display("FAIL %s_changed k=%0d got %b expected 0", tag, k, CHANGED);
      end
    end
    $display("info: %s settle sequence done", tag);
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    SWITCH = 8'hA5;
    repeat (3) tick();
    checks++;
    if (O !== 8'h00) begin
      errors++;
      $display("FAIL reset_o got %h expected 00", O);
    end
    checks++;
    if (VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b expected 0", VALID);
    end
    checks++;
    if (CHANGED !== 1'b0) begin
      errors++;
      $display("FAIL reset_changed got %b expected 0", CHANGED);
    end
    run_settle("reset");
  endtask

  task automatic test_step();
    logic [7:0] exp_o;
    SWITCH = 8'h00;
    repeat (8) tick();
    checks++;
    if (O !== 8'h00) begin
      errors++;
      $display("FAIL step_pre got %h expected 00", O);
    end
    SWITCH = 8'h3C;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_o = (k >= 5) ? 8'h3C : 8'h00;
      checks++;
      if (O !== exp_o || A !== exp_o[3:0] || B !== exp_o[7:4]) begin
        errors++;
        $display("FAIL step_o k=%0d got O=%h A=%h B=%h expected O=%h", k, O, A, B, exp_o);
      end
      checks++;
      if (CHANGED !== (k == 5)) begin
        errors++;
        $display("FAIL step_changed k=%0d got %b expected %b", k, CHANGED, (k == 5));
      end
    end
    $display("info: step 00->3C done");
  endtask

  task automatic test_bounce();
    int pulses;
    SWITCH = 8'h00;
    repeat (8) tick();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      SWITCH[0] = ((i / 2) % 2 == 0);
      tick();
      if (CHANGED === 1'b1) pulses++;
      checks++;
      if (O !== 8'h00) begin
        errors++;
        $display("FAIL bounce_hold i=%0d got %h expected 00", i, O);
      end
    end
    SWITCH[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (CHANGED === 1'b1) pulses++;
      checks++;
      if (O[0] !== (k >= 5)) begin
        errors++;
        $display("FAIL bounce_o0 k=%0d got %b expected %b", k, O[0], (k >= 5));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulses got %0d expected 1", pulses);
    end
    $display("info: bounce on bit 0 done");
  endtask

  task automatic test_glitch();
    logic [7:0] exp_o;
    int pulses;
    for (int k = 0; k < 12; k++) begin
      SWITCH[7] = (k < 3);
      tick();
      checks++;
      if (O !== 8'h01 || CHANGED !== 1'b0) begin
        errors++;
        $display("FAIL glitch3 k=%0d got O=%h CHANGED=%b expected O=01 CHANGED=0", k, O, CHANGED);
      end
    end
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      SWITCH[7] = (k < 4);
      tick();
      if (CHANGED === 1'b1) pulses++;
      exp_o = (k >= 5 && k <= 8) ? 8'h81 : 8'h01;
      checks++;
      if (O !== exp_o) begin
        errors++;
        $display("FAIL glitch4_o k=%0d got %h expected %h", k, O, exp_o);
      end
      checks++;
      if (CHANGED !== (k == 5 || k == 9)) begin
        errors++;
        $display("FAIL glitch4_changed k=%0d got %b expected %b", k, CHANGED, (k == 5 || k == 9));
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL glitch4_pulses got %0d expected 2", pulses);
    end
    $display("info: glitch pulses on bit 7 done");
  endtask

  task automatic test_same_edge();
    logic [7:0] exp_o;
    SWITCH = 8'h80;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_o = (k >= 5) ? 8'h80 : 8'h01;
      checks++;
      if (O !== exp_o) begin
        errors++;
        $display("FAIL same_edge_o k=%0d got %h expected %h", k, O, exp_o);
      end
      checks++;
      if (CHANGED !== (k == 5)) begin
        errors++;
        $display("FAIL same_edge_changed k=%0d got %b expected %b", k, CHANGED, (k == 5));
      end
    end
    $display("info: simultaneous bit 0 / bit 7 change done");
  endtask

  task automatic test_reset_mid();
    SWITCH = 8'h84;
    repeat (4) tick();
    #2;
    RESET  = 1'b1;
    SWITCH = 8'hA5;
    #1;
    checks++;
    if (O !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_o got %h expected 00", O);
    end
    checks++;
    if (VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid got %b expected 0", VALID);
    end
    checks++;
    if (CHANGED !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_changed got %b expected 0", CHANGED);
    end
    repeat (2) tick();
    run_settle("reset_mid");
  endtask

  initial begin
    RESET  = 1'b1;
    SWITCH = 8'h00;
    test_reset();
    test_step();
    test_bounce();
    test_glitch();
    test_same_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the number of consecutive mismatched cycles required before an output bit updates; legal range 2..65535.
REQ-002: CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003: RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-004: SWITCH  input  8  SHALL carry raw, asynchronous, bouncing board switches.
REQ-005: O  output  8  SHALL carry the debounced switch value.
REQ-006: A  output  4  SHALL equal O[3:0] and feed comparator operand I0.
REQ-007: B  output  4  SHALL equal O[7:4] and feed comparator operand I1.
REQ-008: VALID  output  1  SHALL indicate that O has completed its initial settling window.
REQ-009: CHANGED  output  1  SHALL be a one-cycle strobe indicating that O took a new value.

Function
REQ-010: Each SWITCH bit SHALL pass through a two-flop synchronizer, sync1 then sync2, before any use.
REQ-011: Each bit SHALL have an independent 16-bit counter cnt[i].
REQ-012: Per edge, when sync2[i]==O[i], cnt[i] SHALL load 0.
REQ-013: Per edge, when sync2[i]!=O[i] and cnt[i]<DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014: Per edge, when sync2[i]!=O[i] and cnt[i]==DEBOUNCE_CYCLES-1, O[i] SHALL load sync2[i] and cnt[i] SHALL load 0.
REQ-015: Latency: a clean step sampled into sync1 at edge n SHALL appear on O at edge n+DEBOUNCE_CYCLES+1, no earlier and no later.
REQ-016: Any return of sync2[i] to O[i] before the count completes SHALL discard progress; a glitch lasting DEBOUNCE_CYCLES-1 synchronized cycles SHALL never reach O.
REQ-017: Bits SHALL be independent; bits completing on the same edge SHALL update on that same edge.
REQ-018: A global settle counter SHALL count edges after reset release; VALID SHALL rise at edge DEBOUNCE_CYCLES+2 and stay high until the next reset.
REQ-019: CHANGED SHALL be registered with O and high exactly in the cycle after any O bit changes, only when VALID was high at that edge.
REQ-020: Several bits changing on one edge SHALL produce a single-cycle CHANGED; changes on consecutive edges SHALL keep CHANGED high on each corresponding cycle.
REQ-021: O updates during the settling window SHALL never assert CHANGED.
REQ-022: A and B SHALL be pure wiring of O with no added latency.

Reset
REQ-023: While RESET is high, sync1, sync2, O, all cnt[i], the settle counter, VALID, and CHANGED SHALL be 0, taking effect immediately and without a clock edge.
REQ-024: Reset asserted mid-count SHALL discard all in-progress counts; after release, behaviour SHALL be identical to power-up.
REQ-025: Reset release SHALL be the reference point for the edge numbering in REQ-018.

Verification
The bench SHALL use DEBOUNCE_CYCLES=4 and cover the following directed scenarios.
REQ-026: Reset with SWITCH=8'hA5 held -> O=8'h00 and VALID=0 during reset; O=8'hA5 at edge 5, VALID=1 at edge 6, CHANGED never high.
REQ-027: After VALID, SWITCH steps 8'h00 to 8'h3C, sampled at edge n -> O=8'h3C at edge n+5, A=4'hC, B=4'h3, CHANGED high exactly one cycle.
REQ-028: SWITCH[0] toggles every 2 cycles for 20 cycles, then holds 1 -> O[0] stable throughout the bounce; O[0]=1 exactly 5 edges after the final sample; one CHANGED pulse.
REQ-029: A 3-cycle pulse on SWITCH[7] produces no O change; a 4-cycle pulse changes O[7], then the return to 0 restores it 4 synchronized cycles later, with two separate CHANGED pulses.
REQ-030: SWITCH[0] and SWITCH[7] change on the same edge -> both O bits update on the same edge with a single CHANGED pulse.
REQ-031: RESET pulsed asynchronously while cnt[2]==2 -> O, VALID, and CHANGED go to 0 immediately; after release, the settle behaviour matches REQ-026.
